// File: rtl/monitor_reg_engine.sv
// monitor_reg_engine: command execution stage behind the monitor command parser.
// Holds the UART-visible register bank. Writes collect bytes into a shadow
// copy and commit it in one cycle. Reads stream a snapshot out byte 0 first.
// Optional build macro MONITOR_CHECKSUM_EN adds an XOR checksum byte after the
// data bytes. On writes the byte is expected; on reads it is transmitted.
module monitor_reg_engine #(
  parameter int NUM_REGS       = 16,
  parameter int REG_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  input  logic                              cmd_rw,
  input  logic [6:0]                        cmd_id,
  input  logic [7:0]                        data_size,
  output logic                              cmd_ready,
  input  logic                              rx_valid,
  input  logic [7:0]                        rx_data,
  output logic                              tx_valid,
  output logic [7:0]                        tx_data,
  input  logic                              tx_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code,
  output logic [NUM_REGS*REG_BYTES*8-1:0]   reg_q,
  output logic [NUM_REGS-1:0]               reg_wr_stb
);

  localparam int RW = REG_BYTES * 8;
  localparam int KW = $clog2(REG_BYTES + 1) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE_RX = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_READ_TX = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [RW-1:0]        shadow_q, shadow_d;
  logic [KW-1:0]        idx_q, idx_d;
  logic [KW-1:0]        n_q, n_d;
  logic [IW-1:0]        id_q, id_d;
  logic [7:0]           drain_q, drain_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [1:0]           code_q, code_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [NUM_REGS*RW-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]  wr_stb_q, wr_stb_d;
`ifdef MONITOR_CHECKSUM_EN
  logic [7:0]           chk_q, chk_d;
`endif

  logic       id_bad, size_bad, last_data, timed_out;
  logic [7:0] cur_byte;

  assign id_bad    = (32'(cmd_id) >= NUM_REGS);
  assign size_bad  = (data_size == 8'd0) || (32'(data_size) > REG_BYTES);
  assign last_data = ((idx_q + KW'(1)) == n_q);
  assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Select the shadow byte addressed by the current byte index.
  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < REG_BYTES; b++) begin
      if (idx_q == KW'(b)) cur_byte = shadow_q[b*8 +: 8];
    end
  end

  // Next-state and datapath logic for the command engine.
  always_comb begin
    // NOTE: every signal gets a default here, so no path leaves one unassigned
    // and no latch is inferred.
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    n_d        = n_q;
    id_d       = id_q;
    drain_d    = drain_q;
    code_d     = code_q;
    err_code_d = 2'd0;
    regs_d     = regs_q;
    wr_stb_d   = '0;
`ifdef MONITOR_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    // Inter-byte watchdog: cleared by each received byte, saturates otherwise.
    if (rx_valid) timer_d = '0;
    else if (timer_q != '1) timer_d = timer_q + TW'(1);
    else timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (cmd_valid) begin
          idx_d   = '0;
          n_d     = KW'(data_size);
          id_d    = IW'(cmd_id);
          drain_d = data_size;
`ifdef MONITOR_CHECKSUM_EN
          chk_d   = {cmd_rw, cmd_id} ^ data_size;
`endif
          // A write starts from the current value so that unwritten bytes
          // survive the commit. A read snapshots the value it will send.
          for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_id == 7'(i)) shadow_d = regs_q[i*RW +: RW];
          end
          if (cmd_rw) begin
            code_d  = id_bad ? 2'd1 : 2'd2;
            state_d = (id_bad || size_bad) ? S_DRAIN : S_WRITE_RX;
          end else if (id_bad || size_bad) begin
            err_code_d = id_bad ? 2'd1 : 2'd2;
            state_d    = S_DONE;
          end else begin
            state_d = S_READ_TX;
          end
        end
      end

      S_WRITE_RX: begin
        if (rx_valid) begin
          idx_d = idx_q + KW'(1);
`ifdef MONITOR_CHECKSUM_EN
          if (idx_q == n_q) begin
            if (rx_data == chk_q) begin
              state_d = S_COMMIT;
            end else begin
              err_code_d = 2'd3;
              state_d    = S_DONE;
            end
          end else begin
            chk_d = chk_q ^ rx_data;
            for (int b = 0; b < REG_BYTES; b++) begin
              if (idx_q == KW'(b)) shadow_d[b*8 +: 8] = rx_data;
            end
          end
`else
          for (int b = 0; b < REG_BYTES; b++) begin
            if (idx_q == KW'(b)) shadow_d[b*8 +: 8] = rx_data;
          end
          if (last_data) state_d = S_COMMIT;
`endif
        end else if (timed_out) begin
          err_code_d = 2'd3;
          state_d    = S_DONE;
        end
      end

      S_DRAIN: begin
        // Swallow the bytes of a rejected write so the stream stays aligned.
`ifdef MONITOR_CHECKSUM_EN
        if (rx_valid) begin
          if (drain_q == 8'd0) begin
            err_code_d = code_q;
            state_d    = S_DONE;
          end else begin
            drain_d = drain_q - 8'd1;
          end
        end else if (timed_out) begin
          err_code_d = 2'd3;
          state_d    = S_DONE;
        end
`else
        if (drain_q == 8'd0) begin
          err_code_d = code_q;
          state_d    = S_DONE;
        end else if (rx_valid) begin
          if (drain_q == 8'd1) begin
            err_code_d = code_q;
            state_d    = S_DONE;
          end else begin
            drain_d = drain_q - 8'd1;
          end
        end else if (timed_out) begin
          err_code_d = 2'd3;
          state_d    = S_DONE;
        end
`endif
      end

      S_COMMIT: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (id_q == IW'(i)) begin
            regs_d[i*RW +: RW] = shadow_q;
            wr_stb_d[i]        = 1'b1;
          end
        end
        state_d = S_DONE;
      end

      S_READ_TX: begin
        if (tx_ready) begin
          idx_d = idx_q + KW'(1);
`ifdef MONITOR_CHECKSUM_EN
          if (idx_q == n_q) state_d = S_DONE;
          else chk_d = chk_q ^ cur_byte;
`else
          if (last_data) state_d = S_DONE;
`endif
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      id_q       <= '0;
      drain_q    <= '0;
      timer_q    <= '0;
      code_q     <= '0;
      err_code_q <= '0;
      // NOTE: the register bank is architecturally visible and must read as
      // zero after reset, so unlike a scratch RAM it is reset explicitly.
      regs_q     <= '0;
      wr_stb_q   <= '0;
`ifdef MONITOR_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      id_q       <= id_d;
      drain_q    <= drain_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
      err_code_q <= err_code_d;
      regs_q     <= regs_d;
      wr_stb_q   <= wr_stb_d;
`ifdef MONITOR_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Transmit byte: data bytes first, then the checksum when it is built in.
  always_comb begin
    tx_data = '0;
    if (state_q == S_READ_TX) begin
      tx_data = cur_byte;
`ifdef MONITOR_CHECKSUM_EN
      if (idx_q == n_q) tx_data = chk_q;
`endif
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx_valid   = (state_q == S_READ_TX);
  assign done       = (state_q == S_DONE);
  assign error      = done && (err_code_q != 2'd0);
  assign err_code   = err_code_q;
  assign reg_q      = regs_q;
  assign reg_wr_stb = wr_stb_q;

endmodule
